// File: rtl/branch_resolve_unit.sv
// Resolves issued JAL/JALR/Bxx ops in order from a DEPTH-entry FIFO; redirects on mispredict. Optional BEU_MISALIGN_EXC_EN.
// Latency: op issued in cycle t appears on wb (and redirect) in cycle t+2; one result per cycle.
// Backpressure: result reg holds while !wb_ready_i and the FIFO fills; issue_ready_o drops when full or during a redirect.
module branch_resolve_unit #(
  parameter int XLEN  = 64,
  parameter int SID_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             issue_valid_i,
  output logic             issue_ready_o,
  input  logic [XLEN-1:0]  issue_pc_i,
  input  logic [31:0]      issue_inst_i,
  input  logic [SID_W-1:0] issue_sid_i,
  input  logic [3:0]       issue_func_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic             pred_taken_i,
  input  logic [XLEN-1:0]  pred_pc_i,
  output logic             redirect_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [4:0]       wb_rd_o,
  output logic [XLEN-1:0]  wb_value_o,
  output logic [SID_W-1:0] wb_sid_o,
  output logic             exc_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] FUNC_JAL  = 4'b0111;
  localparam logic [3:0] FUNC_JALR = 4'b0101;
  localparam logic [3:0] FUNC_BXX  = 4'b0100;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [31:0]      inst;
    logic [SID_W-1:0] sid;
    logic [3:0]       func;
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic             pred_taken;
    logic [XLEN-1:0]  pred_pc;
  } entry_t;

  entry_t          fifo_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Result register R plus the one-cycle redirect / wrong-path kill pulse.
  logic             r_vld_q, r_exc_q, redirect_q, kill_q;
  logic [4:0]       r_rd_q;
  logic [XLEN-1:0]  r_val_q, r_rpc_q;
  logic [SID_W-1:0] r_sid_q;

  logic   full, empty, push, r_load;
  entry_t head;

  assign full          = (cnt_q == (AW+1)'(DEPTH));
  assign empty         = (cnt_q == '0);
  // Issue is refused in the redirect cycle: anything accepted then is wrong-path.
  assign issue_ready_o = rst_n & ~full & ~kill_q;
  assign push          = issue_valid_i & issue_ready_o & ~flush_i;
  assign head          = fifo_q[rd_ptr_q];
  // The head is never promoted in a kill cycle since it is younger than the mispredict.
  assign r_load        = ~empty & (~r_vld_q | wb_ready_i) & ~kill_q & ~flush_i;

  // Resolution of the FIFO head, evaluated as it is promoted into R.
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, pc4, target, actual_next;
  logic            taken, mispredict, exc_cond;
  logic [4:0]      rd;
  logic            unused_bits;

  assign f3    = head.inst[14:12];
  assign imm_i = {{(XLEN-12){head.inst[31]}}, head.inst[31:20]};
  assign imm_b = {{(XLEN-13){head.inst[31]}}, head.inst[31], head.inst[7],
                  head.inst[30:25], head.inst[11:8], 1'b0};
  assign imm_j = {{(XLEN-21){head.inst[31]}}, head.inst[31], head.inst[19:12],
                  head.inst[20], head.inst[30:21], 1'b0};
  assign pc4   = head.pc + XLEN'(4);
  assign unused_bits = ^{head.inst[6:0], head.inst[24:15]};

  // Decode func/funct3 into taken, target and destination register.
  always_comb begin
    taken  = 1'b0;
    target = pc4;
    rd     = 5'd0;
    case (head.func)
      FUNC_JAL: begin
        taken  = 1'b1;
        target = head.pc + imm_j;
        rd     = head.inst[11:7];
      end
      FUNC_JALR: begin
        taken  = 1'b1;
        target = (head.rs1 + imm_i) & ~XLEN'(1);
        rd     = head.inst[11:7];
      end
      FUNC_BXX: begin
        target = head.pc + imm_b;
        case (f3)
          3'b000:  taken = (head.rs1 == head.rs2);
          3'b001:  taken = (head.rs1 != head.rs2);
          3'b100:  taken = ($signed(head.rs1) <  $signed(head.rs2));
          3'b101:  taken = ($signed(head.rs1) >= $signed(head.rs2));
          3'b110:  taken = (head.rs1 <  head.rs2);
          3'b111:  taken = (head.rs1 >= head.rs2);
          default: taken = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  assign actual_next = taken ? target : pc4;
  assign mispredict  = (taken != head.pred_taken) | (taken & (target != head.pred_pc));

`ifdef BEU_MISALIGN_EXC_EN
  assign exc_cond = taken & (target[1:0] != 2'b00);
`else
  assign exc_cond = 1'b0;
`endif

  // FIFO pointer/count next state; flush or redirect empties it.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i || kill_q) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (r_load) rd_ptr_d = rd_ptr_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(r_load);
    end
  end

  // FIFO pointer/count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{pc: issue_pc_i, inst: issue_inst_i, sid: issue_sid_i,
                             func: issue_func_i, rs1: rs1_i, rs2: rs2_i,
                             pred_taken: pred_taken_i, pred_pc: pred_pc_i};
    end
  end

  // Result register and redirect pulse; redirect fires only on the load into R.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld_q    <= 1'b0;
      r_exc_q    <= 1'b0;
      redirect_q <= 1'b0;
      kill_q     <= 1'b0;
      r_rd_q     <= '0;
      r_val_q    <= '0;
      r_rpc_q    <= '0;
      r_sid_q    <= '0;
    end else if (flush_i) begin
      r_vld_q    <= 1'b0;
      redirect_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      redirect_q <= 1'b0;
      kill_q     <= 1'b0;
      if (r_load) begin
        r_vld_q    <= 1'b1;
        r_exc_q    <= exc_cond;
        r_rd_q     <= exc_cond ? 5'd0 : rd;
        r_val_q    <= pc4;
        r_rpc_q    <= actual_next;
        r_sid_q    <= head.sid;
        redirect_q <= mispredict & ~exc_cond;
        kill_q     <= mispredict | exc_cond;
      end else if (wb_ready_i) begin
        r_vld_q <= 1'b0;
      end
    end
  end

  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_q ? r_rpc_q : '0;
  assign wb_valid_o    = r_vld_q;
  assign wb_rd_o       = r_rd_q;
  assign wb_value_o    = r_val_q;
  assign wb_sid_o      = r_sid_q;
  assign exc_o         = r_vld_q & r_exc_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed ops push expected results,
// a negedge monitor compares each newly presented result and pops on handshake.
module tb_branch_resolve_unit;

  localparam int XLEN = 64;
  localparam int SID_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush_i = 1'b0;
  logic             issue_valid_i = 1'b0;
  logic             issue_ready_o;
  logic [XLEN-1:0]  issue_pc_i = '0;
  logic [31:0]      issue_inst_i = '0;
  logic [SID_W-1:0] issue_sid_i = '0;
  logic [3:0]       issue_func_i = '0;
  logic [XLEN-1:0]  rs1_i = '0, rs2_i = '0;
  logic             pred_taken_i = 1'b0;
  logic [XLEN-1:0]  pred_pc_i = '0;
  logic             redirect_o;
  logic [XLEN-1:0]  redirect_pc_o;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b1;
  logic [4:0]       wb_rd_o;
  logic [XLEN-1:0]  wb_value_o;
  logic [SID_W-1:0] wb_sid_o;
  logic             exc_o;

  branch_resolve_unit #(.XLEN(XLEN), .SID_W(SID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_pc_i(issue_pc_i), .issue_inst_i(issue_inst_i), .issue_sid_i(issue_sid_i),
    .issue_func_i(issue_func_i), .rs1_i(rs1_i), .rs2_i(rs2_i),
    .pred_taken_i(pred_taken_i), .pred_pc_i(pred_pc_i),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o),
    .wb_value_o(wb_value_o), .wb_sid_o(wb_sid_o), .exc_o(exc_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SID_W-1:0] sid;
    logic [4:0]       rd;
    logic [XLEN-1:0]  val;
    logic             redir;
    logic [XLEN-1:0]  rpc;
    logic             exc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [3:0] F_JAL = 4'b0111, F_JALR = 4'b0101, F_BXX = 4'b0100;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, rd, 7'b1100111};
  endfunction

  function automatic exp_t mk(input logic [SID_W-1:0] sid, input logic [4:0] rd,
                              input logic [XLEN-1:0] val, input logic redir,
                              input logic [XLEN-1:0] rpc, input logic exc);
    exp_t e;
    e.sid = sid; e.rd = rd; e.val = val; e.redir = redir; e.rpc = rpc; e.exc = exc;
    return e;
  endfunction

  // Offer one op and hold it until accepted (bounded). Called #1 after posedge.
  task automatic issue(input logic [XLEN-1:0] pc, input logic [31:0] inst, input logic [3:0] func,
                       input logic [SID_W-1:0] sid, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic pt, input logic [XLEN-1:0] ppc);
    int k;
    issue_pc_i = pc; issue_inst_i = inst; issue_func_i = func; issue_sid_i = sid;
    rs1_i = a; rs2_i = b; pred_taken_i = pt; pred_pc_i = ppc;
    issue_valid_i = 1'b1;
    k = 0;
    @(negedge clk);
    while (!issue_ready_o && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) chk("issue_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    issue_valid_i = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((sb.size() != 0 || wb_valid_o) && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (k >= 200) chk("drain_timeout", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare on the first cycle each result is presented, pop on handshake.
  initial begin
    logic prev_hold;
    exp_t e;
    prev_hold = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || flush_i) begin
        prev_hold = 1'b0;
      end else begin
        if (wb_valid_o && !prev_hold) begin
          if (sb.size() == 0) begin
            chk("unexpected_wb_sid", 64'(wb_sid_o), 64'hDEAD);
          end else begin
            e = sb[0];
            chk("wb_sid", 64'(wb_sid_o), 64'(e.sid));
            chk("wb_rd", 64'(wb_rd_o), 64'(e.rd));
            chk("wb_value", wb_value_o, e.val);
            chk("redirect", 64'(redirect_o), 64'(e.redir));
            chk("redirect_pc", redirect_pc_o, e.rpc);
            chk("exc", 64'(exc_o), 64'(e.exc));
          end
        end else if (redirect_o) begin
          chk("redirect_outside_first_cycle", 64'(redirect_o), 64'd0);
        end
        if (wb_valid_o && wb_ready_i && sb.size() != 0) void'(sb.pop_front());
        prev_hold = wb_valid_o && !wb_ready_i;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] pc;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_redirect", 64'(redirect_o), 64'd0);
    chk("rst_redirect_pc", redirect_pc_o, 64'd0);
    chk("rst_wb_rd", 64'(wb_rd_o), 64'd0);
    chk("rst_wb_value", wb_value_o, 64'd0);
    chk("rst_wb_sid", 64'(wb_sid_o), 64'd0);
    chk("rst_exc", 64'(exc_o), 64'd0);
    chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: BEQ 5==5 taken, predicted not taken -> redirect to 0x110 at t+2
    sb.push_back(mk(4'd1, 5'd0, 64'h104, 1'b1, 64'h110, 1'b0));
    issue(64'h100, enc_b(3'b000, 13'd16), F_BXX, 4'd1, 64'd5, 64'd5, 1'b0, 64'h0);
    @(posedge clk);
    #1;
    chk("t2_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("t2_redirect", 64'(redirect_o), 64'd1);
    drain();

    // 2: JAL rd=1 correctly predicted
    sb.push_back(mk(4'd2, 5'd1, 64'h204, 1'b0, 64'h0, 1'b0));
    issue(64'h200, enc_j(5'd1, 21'd8), F_JAL, 4'd2, 64'd0, 64'd0, 1'b1, 64'h208);
    drain();

    // 3: BLT -1<1 taken (correct); BLTU not taken -> redirect to pc+4
    sb.push_back(mk(4'd3, 5'd0, 64'h304, 1'b0, 64'h0, 1'b0));
    issue(64'h300, enc_b(3'b100, 13'h20), F_BXX, 4'd3, '1, 64'd1, 1'b1, 64'h320);
    sb.push_back(mk(4'd4, 5'd0, 64'h404, 1'b1, 64'h404, 1'b0));
    issue(64'h400, enc_b(3'b110, 13'h20), F_BXX, 4'd4, '1, 64'd1, 1'b1, 64'h420);
    drain();

    // 4: backpressure; DEPTH+1 ops accepted, then issue_ready_o low; drain in order
    wb_ready_i = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      pc = 64'h800 + 64'(16 * i);
      sb.push_back(mk(4'(5 + i), 5'(4 + i), pc + 64'd4, 1'b0, 64'h0, 1'b0));
      issue(pc, enc_j(5'(4 + i), 21'd8), F_JAL, 4'(5 + i), 64'd0, 64'd0, 1'b1, pc + 64'd8);
    end
    @(negedge clk);
    chk("full_issue_ready", 64'(issue_ready_o), 64'd0);
    chk("full_wb_sid_held", 64'(wb_sid_o), 64'd5);
    @(posedge clk);
    #1;
    wb_ready_i = 1'b1;
    drain();

    // 5a: mispredicting BNE with two younger ops queued behind it
    wb_ready_i = 1'b0;
    sb.push_back(mk(4'd10, 5'd2, 64'h904, 1'b0, 64'h0, 1'b0));
    issue(64'h900, enc_j(5'd2, 21'd8), F_JAL, 4'd10, 64'd0, 64'd0, 1'b1, 64'h908);
    sb.push_back(mk(4'd11, 5'd0, 64'h504, 1'b1, 64'h504, 1'b0));
    issue(64'h500, enc_b(3'b001, 13'h40), F_BXX, 4'd11, 64'd7, 64'd7, 1'b1, 64'h540);
    issue(64'h504, enc_j(5'd3, 21'd8), F_JAL, 4'd12, 64'd0, 64'd0, 1'b1, 64'h50c);
    issue(64'h50c, enc_j(5'd4, 21'd8), F_JAL, 4'd13, 64'd0, 64'd0, 1'b1, 64'h514);
    wb_ready_i = 1'b1;
    drain();
    repeat (4) @(posedge clk);
    #1;
    chk("dropped_ops_wb_valid", 64'(wb_valid_o), 64'd0);

    // 5b: flush with one op in R and one in the FIFO
    issue(64'h600, enc_j(5'd5, 21'd8), F_JAL, 4'd14, 64'd0, 64'd0, 1'b1, 64'h608);
    issue(64'h610, enc_j(5'd6, 21'd8), F_JAL, 4'd15, 64'd0, 64'd0, 1'b1, 64'h618);
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("flush_redirect", 64'(redirect_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("flush_fifo_empty", 64'(wb_valid_o), 64'd0);

    // 6: JALR to 0x1002 (not word aligned), mispredicted target
`ifdef BEU_MISALIGN_EXC_EN
    sb.push_back(mk(4'd14, 5'd0, 64'h704, 1'b0, 64'h0, 1'b1));
`else
    sb.push_back(mk(4'd14, 5'd3, 64'h704, 1'b1, 64'h1002, 1'b0));
`endif
    issue(64'h700, enc_i(5'd3, 12'd2), F_JALR, 4'd14, 64'h1001, 64'd0, 1'b1, 64'h700);
    drain();

    // Reset mid-operation: op issued, then reset before it reaches R
    issue(64'ha00, enc_j(5'd7, 21'd8), F_JAL, 4'd1, 64'd0, 64'd0, 1'b1, 64'ha08);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_discard", 64'(wb_valid_o), 64'd0);
    chk("midrst_issue_ready", 64'(issue_ready_o), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
